wb_stage: RTL and testbench

Writeback stage directly upstream of the register file. Accepts results from the ALU and the data-memory load path over valid/ready handshakes, buffers them in a small ordered FIFO, and drains one entry per cycle onto the register-file write port (address, data, active-low write enable). Also exports a per-register pending bitmap so operand fetch can stall on read-after-write hazards.

---
 rtl/wb_stage.sv | 99 +++++++++
 tb/tb_wb_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: merges load and ALU results into an ordered FIFO and
// drains one entry per cycle onto the register-file write port.
`timescale 1ns/1ps
module wb_stage #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       wr_we_n,
  output logic [(2**ADDR_W)-1:0]     pending,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  alu_slot;
  logic [CNT_W-1:0]  free;
  logic              push_mem;
  logic              push_alu;
  logic              pop;

  // Acceptance from pre-edge occupancy; the load path claims the first free slot.
  always_comb begin
    free      = CNT_W'(DEPTH) - count;
    mem_ready = (free >= CNT_W'(1));
    alu_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !mem_valid);
    push_mem  = mem_valid && mem_ready;
    push_alu  = alu_valid && alu_ready;
    pop       = (count != '0);
    alu_slot  = wptr + PTR_W'(push_mem);
    empty     = (count == '0) && wr_we_n;
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push_mem) begin
      addr_q[wptr] <= mem_addr;
      data_q[wptr] <= mem_data;
    end
    if (push_alu) begin
      addr_q[alu_slot] <= alu_addr;
      data_q[alu_slot] <= alu_data;
    end
  end

  // Pointers, occupancy, entry valid bits and the registered write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      vld_q   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_we_n <= 1'b1;
    end else begin
      if (pop) begin
        vld_q[rptr] <= 1'b0;
        wr_addr     <= addr_q[rptr];
        wr_data     <= data_q[rptr];
        rptr        <= rptr + PTR_W'(1);
      end
      wr_we_n <= !pop;
      if (push_mem) vld_q[wptr]     <= 1'b1;
      if (push_alu) vld_q[alu_slot] <= 1'b1;
      wptr  <= wptr + PTR_W'(push_mem) + PTR_W'(push_alu);
      count <= count + CNT_W'(push_mem) + CNT_W'(push_alu) - CNT_W'(pop);
    end
  end

  // Hazard bitmap: every queued destination plus the one on the write port.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pending[addr_q[i]] = 1'b1;
    end
    if (!wr_we_n) pending[wr_addr] = 1'b1;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: queue-based reference model checked every cycle,
// plus literal checkpoints for the directed scenarios.
`timescale 1ns/1ps
module tb_wb_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [3:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_we_n;
  logic [15:0] pending;
  logic [2:0]  count;
  logic        empty;

  int total = 0;
  int bad   = 0;

  wb_stage #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_we_n(wr_we_n),
    .pending(pending), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of queued writes plus the current port contents.
  typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic        m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] regs [16];
  bit          chk_on = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_we = 0; m_addr = '0; m_data = '0;
    end else begin
      int n, fr;
      bit ma, aa;
      ent_t e;
      n  = q.size();
      fr = DEPTH - n;
      ma = mem_valid && (fr >= 1);
      aa = alu_valid && ((fr >= 2) || (fr >= 1 && !mem_valid));
      if (n > 0) begin
        m_we = 1; m_addr = q[0].a; m_data = q[0].d;
        void'(q.pop_front());
      end else begin
        m_we = 0;
      end
      if (ma) begin e.a = mem_addr; e.d = mem_data; q.push_back(e); end
      if (aa) begin e.a = alu_addr; e.d = alu_data; q.push_back(e); end
    end
  end

  // Per-cycle comparison against the model, then register-file update.
  always @(negedge clk) begin
    if (chk_on) begin
      int fr;
      logic [15:0] p;
      fr = DEPTH - q.size();
      p  = '0;
      foreach (q[i]) p[q[i].a] = 1'b1;
      if (m_we) p[m_addr] = 1'b1;
      chk("mem_ready", 64'(mem_ready), 64'(fr >= 1));
      chk("alu_ready", 64'(alu_ready), 64'((fr >= 2) || (fr >= 1 && !mem_valid)));
      chk("wr_we_n",   64'(wr_we_n),   64'(!m_we));
      chk("wr_addr",   64'(wr_addr),   64'(m_addr));
      chk("wr_data",   64'(wr_data),   64'(m_data));
      chk("count",     64'(count),     64'(q.size()));
      chk("empty",     64'(empty),     64'(q.size() == 0 && !m_we));
      chk("pending",   64'(pending),   64'(p));
      if (m_we && !rst) regs[m_addr] = m_data;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_valid = 0; alu_valid = 0;
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
  endtask

  initial begin
    int mi, ai, guard;
    bit ma, aa;
    foreach (regs[i]) regs[i] = '0;
    idle_in();
    rst = 1'b1;
    repeat (2) cyc();
    // Reset values
    chk("rst_we_n",    64'(wr_we_n), 64'd1);
    chk("rst_addr",    64'(wr_addr), 64'd0);
    chk("rst_data",    64'(wr_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_empty",   64'(empty),   64'd1);
    chk("rst_count",   64'(count),   64'd0);
    rst = 1'b0;
    chk_on = 1;
    #1;
    chk("rel_mem_ready", 64'(mem_ready), 64'd1);
    chk("rel_alu_ready", 64'(alu_ready), 64'd1);
    cyc();

    // Single ALU push: addr 3 = 0xAA
    alu_valid = 1; alu_addr = 4'd3; alu_data = 32'h0000_00AA;
    cyc();
    idle_in();
    chk("s1_pend_a", 64'(pending), 64'h0008);
    chk("s1_we_a",   64'(wr_we_n), 64'd1);
    cyc();
    chk("s1_we_b",   64'(wr_we_n), 64'd0);
    chk("s1_addr",   64'(wr_addr), 64'd3);
    chk("s1_data",   64'(wr_data), 64'hAA);
    chk("s1_pend_b", 64'(pending), 64'h0008);
    cyc();
    chk("s1_empty",  64'(empty),   64'd1);
    chk("s1_pend_c", 64'(pending), 64'h0000);

    // Simultaneous mem (1=0x11) and alu (2=0x22) into an empty FIFO
    mem_valid = 1; mem_addr = 4'd1; mem_data = 32'h11;
    alu_valid = 1; alu_addr = 4'd2; alu_data = 32'h22;
    cyc();
    idle_in();
    chk("s2_count", 64'(count), 64'd2);
    cyc();
    chk("s2_first", 64'({wr_we_n, wr_addr, wr_data}), {31'd0, 1'b0, 4'd1, 32'h11});
    cyc();
    chk("s2_second", 64'({wr_we_n, wr_addr, wr_data}), {31'd0, 1'b0, 4'd2, 32'h22});
    cyc();

    // Sustained ALU stream, mem idle
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1; alu_addr = 4'd7; alu_data = 32'h300 + 32'(i);
      #1;
      chk("s3_alu_ready", 64'(alu_ready), 64'd1);
      cyc();
      chk("s3_cnt_le1", 64'(count <= 3'd1), 64'd1);
    end
    idle_in();
    repeat (3) cyc();

    // Both sources streaming until each has delivered four entries
    mi = 0; ai = 0; guard = 0;
    while ((mi < 4 || ai < 4) && guard < 40) begin
      mem_valid = (mi < 4); mem_addr = 4'(8 + mi);  mem_data = 32'h100 + 32'(mi);
      alu_valid = (ai < 4); alu_addr = 4'(12 + ai); alu_data = 32'h200 + 32'(ai);
      @(negedge clk);
      ma = mem_valid && mem_ready;
      aa = alu_valid && alu_ready;
      cyc();
      if (ma) mi++;
      if (aa) ai++;
      guard++;
    end
    chk("s4_done", 64'(mi == 4 && ai == 4), 64'd1);
    idle_in();
    repeat (8) cyc();

    // Two writes to register 5
    alu_valid = 1; alu_addr = 4'd5; alu_data = 32'h1;
    cyc();
    alu_data = 32'h2;
    cyc();
    idle_in();
    chk("s5_pend_a", 64'(pending[5]), 64'd1);
    cyc();
    chk("s5_pend_b", 64'(pending[5]), 64'd1);
    chk("s5_data_b", 64'(wr_data), 64'h2);
    cyc();
    chk("s5_pend_c", 64'(pending[5]), 64'd0);

    // Reset with count=3 and an active write port
    mem_valid = 1; mem_addr = 4'd9;  mem_data = 32'hA1;
    alu_valid = 1; alu_addr = 4'd10; alu_data = 32'hA2;
    cyc();
    mem_addr = 4'd11; mem_data = 32'hA3;
    alu_addr = 4'd4;  alu_data = 32'hA4;
    cyc();
    idle_in();
    chk("s6_pre_cnt", 64'(count),   64'd3);
    chk("s6_pre_we",  64'(wr_we_n), 64'd0);
    rst = 1'b1;
    #1;
    chk("s6_we_n",   64'(wr_we_n), 64'd1);
    chk("s6_pend",   64'(pending), 64'd0);
    chk("s6_count",  64'(count),   64'd0);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("s6_no_write", 64'(wr_we_n), 64'd1);
    end

    // Register-file contents as seen through the model
    chk("rf3",  64'(regs[3]),  64'hAA);
    chk("rf1",  64'(regs[1]),  64'h11);
    chk("rf2",  64'(regs[2]),  64'h22);
    chk("rf5",  64'(regs[5]),  64'h2);
    chk("rf7",  64'(regs[7]),  64'h305);
    chk("rf11", 64'(regs[11]), 64'h103);
    chk("rf15", 64'(regs[15]), 64'h203);
    chk("rf4",  64'(regs[4]),  64'h0);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
